// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register completer.
// FSM states, register map addresses, counter widths and byte-lane merge.
package apb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] REG_BASE    = 16'h0000;
  localparam logic [15:0] ID_ADDR     = 16'h0020;
  localparam logic [15:0] STATUS_ADDR = 16'h0024;

  localparam int NUM_REGS = 8;
  localparam int ERR_W    = 8;
  localparam int CNT_W    = 4;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: load, decrement, zero flag.
// Latency: load/decrement take effect on the next pclk edge.
// Backpressure: none; the controller decides when to load or decrement.
module apb_wait_counter #(
  parameter int W = 4
) (
  input  logic         pclk,
  input  logic         presetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_reg_completer.sv
// APB4 completer: eight RW registers, a read-only ID word and a STATUS word.
// Latency: pready pulses once, WAIT_CYCLES+1 cycles after the first access cycle.
// Backpressure: holds pready low for WAIT_CYCLES; dropping psel/penable in WAIT abandons the access.
module apb_reg_completer
  import apb_reg_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] paddr,
  input  logic [2:0]  pprot,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pwstrb,
  input  logic        pwakeup,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic              acc;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [15:0]       addr_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [31:0]       regs [NUM_REGS];
  logic [ERR_W-1:0]  err_cnt_q;
  logic              wake_q;

  logic [15:0]       cur_addr;
  logic              cur_wr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_strb;
  logic              in_regs, is_id, is_status, dec_err, enter_resp;
  logic [31:0]       rd_val, status_word;
  logic              unused_pprot;

  assign unused_pprot = ^pprot;
  assign acc = psel & penable;

  // With no wait states the response is decided on the IDLE edge itself, so decode the live bus then.
  assign cur_addr  = (state_q == IDLE) ? paddr  : addr_q;
  assign cur_wr    = (state_q == IDLE) ? pwrite : wr_q;
  assign cur_wdata = (state_q == IDLE) ? pwdata : wdata_q;
  assign cur_strb  = (state_q == IDLE) ? pwstrb : strb_q;

  assign in_regs     = ({cur_addr[15:5], 3'b000, cur_addr[1:0]} == REG_BASE);
  assign is_id       = (cur_addr == ID_ADDR);
  assign is_status   = (cur_addr == STATUS_ADDR);
  assign dec_err     = !(in_regs || (!cur_wr && (is_id || is_status)));
  assign status_word = 32'({err_cnt_q, 7'd0, wake_q});
  assign rd_val      = in_regs   ? regs[cur_addr[4:2]] :
                       is_id     ? ID_VALUE :
                       is_status ? status_word : 32'h0;
  assign enter_resp  = (state_d == RESP);

  apb_wait_counter #(.W(CNT_W)) u_wait (
    .pclk     (pclk),
    .presetn  (presetn),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          cnt_load = 1'b1;
          state_d  = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!acc)          state_d = IDLE;
        else if (cnt_zero) state_d = RESP;
        else               cnt_dec = 1'b1;
      end
      RESP:    state_d = penable ? DONE : IDLE;
      DONE:    if (!penable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      pready    <= 1'b0;
      prdata    <= 32'h0;
      pslverr   <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_cnt_q <= '0;
      wake_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      wake_q  <= pwakeup;
      if ((state_q == IDLE) && acc) begin
        addr_q  <= paddr;
        wr_q    <= pwrite;
        wdata_q <= pwdata;
        strb_q  <= pwstrb;
      end
      pready  <= enter_resp;
      pslverr <= enter_resp && dec_err;
      prdata  <= (enter_resp && !dec_err && !cur_wr) ? rd_val : 32'h0;
      if (enter_resp && dec_err && (err_cnt_q != {ERR_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
      // Writes land on the edge entering RESP, ahead of any access that follows.
      if (enter_resp && !dec_err && cur_wr) begin
        regs[cur_addr[4:2]] <= apply_strb(regs[cur_addr[4:2]], cur_wdata, cur_strb);
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: three instances (0, 3 and 5 wait states) against a transaction-level model.
module tb_apb_reg_completer;

  localparam int N = 3;

  function automatic int wc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
  endfunction

  logic        pclk = 1'b0;
  logic        presetn [N];
  logic        psel [N];
  logic        penable [N];
  logic        pwrite [N];
  logic [15:0] paddr [N];
  logic [2:0]  pprot [N];
  logic [31:0] pwdata [N];
  logic [3:0]  pwstrb [N];
  logic        pwakeup [N];
  logic        pready [N];
  logic [31:0] prdata [N];
  logic        pslverr [N];

  logic        exp_rdy [N];
  logic [31:0] exp_rdata [N];
  logic        exp_err [N];

  logic [31:0] m_regs [N][8];
  logic [7:0]  m_err [N];
  logic        m_w1 [N];
  logic        m_w2 [N];

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    apb_reg_completer #(
      .WAIT_CYCLES (wc_of(g)),
      .ID_VALUE    (32'hA9B0_0001)
    ) u_dut (
      .pclk    (pclk),
      .presetn (presetn[g]),
      .psel    (psel[g]),
      .penable (penable[g]),
      .pwrite  (pwrite[g]),
      .paddr   (paddr[g]),
      .pprot   (pprot[g]),
      .pwdata  (pwdata[g]),
      .pwstrb  (pwstrb[g]),
      .pwakeup (pwakeup[g]),
      .pready  (pready[g]),
      .prdata  (prdata[g]),
      .pslverr (pslverr[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // STATUS bit0 reflects pwakeup as it stood one edge before the response is latched.
  always @(posedge pclk) begin
    for (int k = 0; k < N; k++) begin
      if (!presetn[k]) begin
        m_w1[k] <= 1'b0;
        m_w2[k] <= 1'b0;
      end else begin
        m_w2[k] <= m_w1[k];
        m_w1[k] <= pwakeup[k];
      end
    end
  end

  always @(negedge pclk) begin
    if (run) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("u%0d.pready", k),  32'(pready[k]),  32'(exp_rdy[k]));
        check($sformatf("u%0d.prdata", k),  prdata[k],       exp_rdata[k]);
        check($sformatf("u%0d.pslverr", k), 32'(pslverr[k]), 32'(exp_err[k]));
      end
    end
  end

  function automatic bit m_is_err(input bit wr, input logic [15:0] a);
    if (a[1:0] != 2'b00) return 1'b1;
    if (a > 16'h0024) return 1'b1;
    if (wr && (a >= 16'h0020)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [15:0] a);
    if (a < 16'h0020) return m_regs[k][a[4:2]];
    if (a == 16'h0020) return 32'hA9B0_0001;
    return {16'h0, m_err[k], 7'h0, m_w2[k]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic m_reset(input int k);
    for (int i = 0; i < 8; i++) m_regs[k][i] = 32'h0;
    m_err[k] = 8'h0;
  endtask

  task automatic set_exp(input int k, input logic r, input logic [31:0] d, input logic e);
    exp_rdy[k] = r;
    exp_rdata[k] = d;
    exp_err[k] = e;
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic step(input int k, input int c, inout int lat, inout logic [31:0] got, inout logic got_err);
    @(negedge pclk);
    if ((pready[k] === 1'b1) && (lat == -1)) begin
      lat = c;
      got = prdata[k];
      got_err = pslverr[k];
    end
    tick();
  endtask

  task automatic idle(input int k, input int n);
    int lat;
    logic [31:0] got;
    logic ge;
    lat = -1;
    got = '0;
    ge = 1'b0;
    psel[k] = 1'b0;
    penable[k] = 1'b0;
    set_exp(k, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < n; i++) step(k, 99, lat, got, ge);
  endtask

  // hold<0 releases penable inside the pready cycle; drop_at/rst_at index access cycles from 0.
  task automatic access(input int k, input bit wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input bit setup, input int hold, input int drop_at,
                        input int rst_at, output logic [31:0] got, output logic got_err, output int lat);
    int w;
    int last;
    bit e;
    logic [31:0] rd;
    w = wc_of(k);
    got = '0;
    got_err = 1'b0;
    lat = -1;
    pwrite[k] = wr;
    paddr[k] = a;
    pwdata[k] = wd;
    pwstrb[k] = st;
    pprot[k] = 3'($urandom);
    set_exp(k, 1'b0, 32'h0, 1'b0);
    if (setup) begin
      psel[k] = 1'b1;
      penable[k] = 1'b0;
      step(k, 99, lat, got, got_err);
    end
    psel[k] = 1'b1;
    penable[k] = 1'b1;
    last = w + 1 + ((hold > 0) ? hold : 0);
    for (int c = 0; c <= last; c++) begin
      set_exp(k, 1'b0, 32'h0, 1'b0);
      if (c == rst_at) begin
        presetn[k] = 1'b0;
        psel[k] = 1'b0;
        penable[k] = 1'b0;
        m_reset(k);
        step(k, c, lat, got, got_err);
        presetn[k] = 1'b1;
        break;
      end
      if (c == drop_at) begin
        psel[k] = 1'b0;
        step(k, c, lat, got, got_err);
        break;
      end
      if (c == w + 1) begin
        e = m_is_err(wr, a);
        rd = (e || wr) ? 32'h0 : m_read(k, a);
        set_exp(k, 1'b1, rd, e);
        if (e) begin
          if (m_err[k] != 8'hFF) m_err[k] = m_err[k] + 8'd1;
        end else if (wr) begin
          m_regs[k][a[4:2]] = merge(m_regs[k][a[4:2]], wd, st);
        end
        if (hold < 0) begin
          psel[k] = 1'b0;
          penable[k] = 1'b0;
        end
      end
      step(k, c, lat, got, got_err);
    end
    psel[k] = 1'b0;
    penable[k] = 1'b0;
    set_exp(k, 1'b0, 32'h0, 1'b0);
    step(k, 99, lat, got, got_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time budget exhausted at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic ge;
    int lat;
    logic [15:0] a;
    bit wr;
    int drop, hold;

    for (int k = 0; k < N; k++) begin
      presetn[k] = 1'b0;
      psel[k] = 1'b0;
      penable[k] = 1'b0;
      pwrite[k] = 1'b0;
      paddr[k] = '0;
      pprot[k] = '0;
      pwdata[k] = '0;
      pwstrb[k] = '0;
      pwakeup[k] = 1'b0;
      set_exp(k, 1'b0, 32'h0, 1'b0);
      m_reset(k);
    end
    tick();
    run = 1'b1;
    tick();
    tick();
    for (int k = 0; k < N; k++) presetn[k] = 1'b1;
    tick();

    // Reset state of the register file and STATUS.
    access(0, 0, 16'h0000, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("rst_reg0", got, 32'h0);
    access(0, 0, 16'h0024, 32'h0, 4'h0, 1, 0, -1, -1, got, ge, lat);
    check("rst_status", got, 32'h0);

    // Zero-wait write then read of REG0.
    access(0, 1, 16'h0000, 32'hDEAD_BEEF, 4'hF, 0, 0, -1, -1, got, ge, lat);
    check("w0_lat", 32'(lat), 32'd1);
    check("w0_err", 32'(ge), 32'd0);
    access(0, 0, 16'h0000, 32'h0, 4'h0, 0, -1, -1, -1, got, ge, lat);
    check("r0_lat", 32'(lat), 32'd1);
    check("r0_data", got, 32'hDEAD_BEEF);
    check("r0_err", 32'(ge), 32'd0);

    // Byte-lane strobes on REG1.
    access(0, 1, 16'h0004, 32'h1122_3344, 4'hF, 1, 0, -1, -1, got, ge, lat);
    access(0, 1, 16'h0004, 32'hAABB_CCDD, 4'h5, 0, 1, -1, -1, got, ge, lat);
    access(0, 0, 16'h0004, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("r1_strb", got, 32'h11BB_33DD);

    // Empty strobe is a clean no-op.
    access(0, 1, 16'h0008, 32'hFFFF_FFFF, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("w2_nostrb_err", 32'(ge), 32'd0);
    access(0, 0, 16'h0008, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("r2_nostrb", got, 32'h0);

    // Error responses and the STATUS error count.
    access(0, 1, 16'h0002, 32'h5555_5555, 4'hF, 0, 0, -1, -1, got, ge, lat);
    check("err_misalign", 32'(ge), 32'd1);
    access(0, 1, 16'h0020, 32'h5555_5555, 4'hF, 1, 0, -1, -1, got, ge, lat);
    check("err_wr_id", 32'(ge), 32'd1);
    access(0, 0, 16'h0100, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("err_range", 32'(ge), 32'd1);
    check("err_range_data", got, 32'h0);
    access(0, 0, 16'h0024, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("status_errcnt", got, 32'h0000_0300);
    access(0, 0, 16'h0000, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("r0_after_err", got, 32'hDEAD_BEEF);

    // Wakeup hint in STATUS bit0.
    pwakeup[0] = 1'b1;
    idle(0, 2);
    pwakeup[0] = 1'b0;
    access(0, 0, 16'h0024, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("status_wake1", got, 32'h0000_0301);
    idle(0, 3);
    access(0, 0, 16'h0024, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("status_wake0", got, 32'h0000_0300);

    // Three wait states, penable held three extra cycles.
    access(1, 0, 16'h0020, 32'h0, 4'h0, 1, 3, -1, -1, got, ge, lat);
    check("id_lat", 32'(lat), 32'd4);
    check("id_data", got, 32'hA9B0_0001);
    check("id_err", 32'(ge), 32'd0);

    // Five wait states: abandoned write, then resets mid-wait and mid-response.
    access(2, 1, 16'h0008, 32'h1234_5678, 4'hF, 0, 0, -1, -1, got, ge, lat);
    access(2, 1, 16'h0008, 32'hFFFF_FFFF, 4'hF, 1, 0, 2, -1, got, ge, lat);
    check("drop_nordy", 32'(lat), 32'hFFFF_FFFF);
    access(2, 0, 16'h0008, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("drop_reg2", got, 32'h1234_5678);
    access(2, 1, 16'h000C, 32'hCAFE_F00D, 4'hF, 0, 0, -1, -1, got, ge, lat);
    access(2, 1, 16'h000C, 32'h0BAD_0BAD, 4'hF, 0, 0, -1, 3, got, ge, lat);
    check("rst_wait_nordy", 32'(lat), 32'hFFFF_FFFF);
    access(2, 0, 16'h000C, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("rst_reg3", got, 32'h0);
    access(2, 0, 16'h0008, 32'h0, 4'h0, 0, 0, -1, -1, got, ge, lat);
    check("rst_reg2", got, 32'h0);
    access(2, 0, 16'h0020, 32'h0, 4'h0, 0, 0, -1, 6, got, ge, lat);
    check("rst_resp_nordy", 32'(lat), 32'hFFFF_FFFF);

    // Randomized traffic on every instance.
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 40; t++) begin
        wr = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0: a = 16'($urandom_range(0, 48));
          1: a = 16'h0024;
          2: a = 16'h0020;
          3: a = 16'($urandom);
          default: a = 16'($urandom_range(0, 12) * 4);
        endcase
        pwakeup[k] = 1'($urandom_range(0, 1));
        drop = ((wc_of(k) > 0) && ($urandom_range(0, 5) == 0)) ? int'($urandom_range(1, wc_of(k))) : -1;
        hold = int'($urandom_range(0, 4)) - 1;
        access(k, wr, a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), hold, drop, -1, got, ge, lat);
      end
      pwakeup[k] = 1'b0;
    end

    idle(0, 2);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
